bus_uart_tx: RTL

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/uart_pkg.sv | 32 +++
 rtl/bus_uart_tx_if.sv | 24 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/bus_uart_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the bus-mapped UART: register map, status bit positions,
// transmitter state encoding and bus widths.
package uart_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIV_W  = 16;

    localparam int unsigned REG_TXDATA  = 0;
    localparam int unsigned REG_STATUS  = 1;
    localparam int unsigned REG_DIVISOR = 2;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // A divisor of zero still yields a one-cycle bit.
    function automatic logic [DIV_W-1:0] period_of(input logic [DIV_W-1:0] div);
        return (div == '0) ? DIV_W'(1) : div;
    endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// CPU word bus as seen by a memory-mapped peripheral; read data is OR-combinable.
interface bus_uart_tx_if;
    import uart_pkg::*;

    logic [ADDR_W-1:0] bus_addr;
    logic [BUS_W-1:0]  bus_data_w;
    logic [MASK_W-1:0] bus_mask_w;
    logic [BUS_W-1:0]  bus_data_r;

    modport master (
        output bus_addr,
        output bus_data_w,
        output bus_mask_w,
        input  bus_data_r
    );

    modport slave (
        input  bus_addr,
        input  bus_data_w,
        input  bus_mask_w,
        output bus_data_r
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-based full/empty; a push while full is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop_c;
    logic             do_push_c;
    logic [CW-1:0]    count_next_c;

    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign head_c    = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (do_push_c && !do_pop_c) begin
            count_next_c = count + CW'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_next_c = count - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next_c;
            full  <= (count_next_c == CW'(DEPTH));
            empty <= (count_next_c == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers in front of
// a byte FIFO feeding a start/data/stop serializer.
module bus_uart_tx
    import uart_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE     = 30'h0400_0000,
    parameter int unsigned       DEPTH    = 8,
    parameter logic [DIV_W-1:0]  DIV_INIT = 16'd16
) (
    input  logic          clock,
    input  logic          reset,
    bus_uart_tx_if.slave  bus,
    output logic          txd
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              hit_c;
    logic              wr_c;
    logic [1:0]        reg_c;
    logic              push_c;
    logic              pop_c;
    logic              ovf_clr_c;
    logic              div_wr_c;
    logic              bit_end_c;
    logic [BUS_W-1:0]  status_c;
    logic [BYTE_W-1:0] head_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              unused_c;

    logic              overflow;
    logic [DIV_W-1:0]  div;
    tx_state_t         state;
    logic [BYTE_W-1:0] shift_q;
    logic [DIV_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  period_q;
    logic [2:0]        bit_idx;

    assign hit_c     = (bus.bus_addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    assign reg_c     = bus.bus_addr[1:0];
    assign wr_c      = |bus.bus_mask_w;
    assign push_c    = hit_c && wr_c && (reg_c == 2'(REG_TXDATA)) && bus.bus_mask_w[0];
    assign ovf_clr_c = hit_c && wr_c && (reg_c == 2'(REG_STATUS)) && bus.bus_mask_w[0]
                       && bus.bus_data_w[ST_OVF];
    assign div_wr_c  = hit_c && wr_c && (reg_c == 2'(REG_DIVISOR));
    assign bit_end_c = (bit_cnt == period_q - DIV_W'(1));
    assign pop_c     = !fifo_empty && ((state == TX_IDLE) || ((state == TX_STOP) && bit_end_c));
    assign unused_c  = ^{bus.bus_data_w[BUS_W-1:DIV_W], fifo_count};

    always_comb begin
        status_c           = '0;
        status_c[ST_FULL]  = fifo_full;
        status_c[ST_EMPTY] = fifo_empty;
        status_c[ST_BUSY]  = (state != TX_IDLE);
        status_c[ST_OVF]   = overflow;
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push_c),
        .pop    (pop_c),
        .wdata  (bus.bus_data_w[BYTE_W-1:0]),
        .head_c (head_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Register file and one-cycle read path; non-read cycles return zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow       <= 1'b0;
            div            <= DIV_INIT;
            bus.bus_data_r <= '0;
        end else begin
            if (ovf_clr_c) begin
                overflow <= 1'b0;
            end else if (push_c && fifo_full && !pop_c) begin
                overflow <= 1'b1;
            end
            if (div_wr_c && bus.bus_mask_w[0]) begin
                div[7:0] <= bus.bus_data_w[7:0];
            end
            if (div_wr_c && bus.bus_mask_w[1]) begin
                div[15:8] <= bus.bus_data_w[15:8];
            end
            if (hit_c && !wr_c) begin
                case (reg_c)
                    2'(REG_STATUS):  bus.bus_data_r <= status_c;
                    2'(REG_DIVISOR): bus.bus_data_r <= BUS_W'(div);
                    default:         bus.bus_data_r <= '0;
                endcase
            end else begin
                bus.bus_data_r <= '0;
            end
        end
    end

    // Serializer; the bit period is re-sampled from div at every bit boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= TX_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            period_q <= DIV_W'(1);
            bit_idx  <= '0;
            txd      <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        state    <= TX_START;
                        shift_q  <= head_c;
                        txd      <= 1'b0;
                        bit_cnt  <= '0;
                        period_q <= period_of(div);
                    end
                end
                TX_START: begin
                    if (bit_end_c) begin
                        state    <= TX_DATA;
                        txd      <= shift_q[0];
                        bit_idx  <= '0;
                        bit_cnt  <= '0;
                        period_q <= period_of(div);
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end_c) begin
                        bit_cnt  <= '0;
                        period_q <= period_of(div);
                        if (bit_idx == 3'(BYTE_W - 1)) begin
                            state <= TX_STOP;
                            txd   <= 1'b1;
                        end else begin
                            shift_q <= {1'b0, shift_q[BYTE_W-1:1]};
                            txd     <= shift_q[1];
                            bit_idx <= bit_idx + 3'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end_c) begin
                        bit_cnt  <= '0;
                        period_q <= period_of(div);
                        if (!fifo_empty) begin
                            state   <= TX_START;
                            shift_q <= head_c;
                            txd     <= 1'b0;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
